// File: rtl/buffer_score_pkg.sv
// +------------------------------------------------------------------+
// | buffer_score_pkg : shared widths, score weights and mode type    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package buffer_score_pkg;

    localparam int SLOTS       = 6;
    localparam int SLOT_W      = 3;
    localparam int BUF_W       = 18;
    localparam int CNT_W       = 3;
    localparam int SCORE_W     = 6;
    localparam int DEFAULT_DIV = 150_000_000;

    localparam logic [SCORE_W-1:0] RW1 = 6'd1;
    localparam logic [SCORE_W-1:0] RW2 = 6'd2;
    localparam logic [SCORE_W-1:0] RW3 = 6'd3;
    localparam logic [SCORE_W-1:0] RW4 = 6'd4;
    localparam logic [SCORE_W-1:0] LW1 = 6'd4;
    localparam logic [SCORE_W-1:0] LW2 = 6'd3;
    localparam logic [SCORE_W-1:0] LW3 = 6'd2;
    localparam logic [SCORE_W-1:0] LW4 = 6'd1;

    typedef enum logic {
        LATENCY     = 1'b0,
        RELIABILITY = 1'b1
    } mode_t;

    // Preferred buffer: latency mode favours low indices, reliability high ones.
    function automatic logic [1:0] pick_buffer(
        input mode_t            m,
        input logic [CNT_W-1:0] c1,
        input logic [CNT_W-1:0] c2,
        input logic [CNT_W-1:0] c3,
        input logic [CNT_W-1:0] c4
    );
        logic [1:0] r_sel;
        if (m == LATENCY) begin
            if ((c1 > c2) && (c1 > c3) && (c1 > c4)) begin
                r_sel = 2'd0;
            end else if ((c2 > c1) && (c2 > c3) && (c2 > c4)) begin
                r_sel = 2'd1;
            end else if (c3 > c4) begin
                r_sel = 2'd2;
            end else begin
                r_sel = 2'd3;
            end
        end else begin
            if ((c4 > c1) && (c4 > c2) && (c4 > c3)) begin
                r_sel = 2'd3;
            end else if ((c3 > c1) && (c3 > c2) && (c3 > c4)) begin
                r_sel = 2'd2;
            end else if (c2 > c1) begin
                r_sel = 2'd1;
            end else begin
                r_sel = 2'd0;
            end
        end
        return r_sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/buffer_score_core_counter.sv
// +------------------------------------------------------------------+
// | buf_slot_counter : counts slots whose valid bit is set           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module buf_slot_counter
    import buffer_score_pkg::*;
(
    input  logic [BUF_W-1:0] buf_i,
    output logic [CNT_W-1:0] count_o
);

    logic [2*SLOTS-1:0] w_payload;
    logic               w_payload_unused;

    // Payload bits play no part in the count.
    for (genvar g = 0; g < SLOTS; g++) begin : g_payload
        assign w_payload[2*g+1:2*g] = buf_i[g*SLOT_W+2:g*SLOT_W+1];
    end

    assign w_payload_unused = ^w_payload;

    always_comb begin
        count_o = '0;
        for (int k = 0; k < SLOTS; k++) begin
            count_o = count_o + CNT_W'(buf_i[k*SLOT_W]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/buffer_score_core.sv
// +------------------------------------------------------------------+
// | buffer_score_core : slot counts, scores, tick divider and mode   |
// | latch; optional ARB_SEL_EN adds registered sel/sel_valid.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module buffer_score_core
    import buffer_score_pkg::*;
#(
    parameter int DIV_CYCLES = DEFAULT_DIV
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BUF_W-1:0]   buffer1_i,
    input  logic [BUF_W-1:0]   buffer2_i,
    input  logic [BUF_W-1:0]   buffer3_i,
    input  logic [BUF_W-1:0]   buffer4_i,
    output logic [CNT_W-1:0]   l1,
    output logic [CNT_W-1:0]   l2,
    output logic [CNT_W-1:0]   l3,
    output logic [CNT_W-1:0]   l4,
    output logic [SCORE_W-1:0] rs,
    output logic [SCORE_W-1:0] ls,
    output logic               tick,
    output logic               clk_out,
    output logic               mode
`ifdef ARB_SEL_EN
    ,
    output logic [1:0]         sel,
    output logic               sel_valid
`endif
);

    localparam int             CW         = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0]  c_cnt_last = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0]  c_cnt_half = CW'(DIV_CYCLES / 2 - 1);

    logic [BUF_W-1:0] w_buf [4];
    logic [CNT_W-1:0] w_cnt [4];

    assign w_buf[0] = buffer1_i;
    assign w_buf[1] = buffer2_i;
    assign w_buf[2] = buffer3_i;
    assign w_buf[3] = buffer4_i;

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        buf_slot_counter u_cnt (
            .buf_i   (w_buf[g]),
            .count_o (w_cnt[g])
        );
    end

    assign l1 = w_cnt[0];
    assign l2 = w_cnt[1];
    assign l3 = w_cnt[2];
    assign l4 = w_cnt[3];

    logic [SCORE_W-1:0] w_l1_x, w_l2_x, w_l3_x, w_l4_x;

    assign w_l1_x = {{(SCORE_W-CNT_W){1'b0}}, l1};
    assign w_l2_x = {{(SCORE_W-CNT_W){1'b0}}, l2};
    assign w_l3_x = {{(SCORE_W-CNT_W){1'b0}}, l3};
    assign w_l4_x = {{(SCORE_W-CNT_W){1'b0}}, l4};

    // Maximum is 10*6 = 60, so 6 bits never overflow.
    assign rs = w_l1_x * RW1 + w_l2_x * RW2 + w_l3_x * RW3 + w_l4_x * RW4;
    assign ls = w_l1_x * LW1 + w_l2_x * LW2 + w_l3_x * LW3 + w_l4_x * LW4;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_out_q, clk_out_d;
    mode_t         mode_q, mode_d;
    mode_t         w_mode_now;

    assign tick       = (cnt_q == c_cnt_last);
    assign w_mode_now = (rs >= ls) ? RELIABILITY : LATENCY;

    always_comb begin
        cnt_d     = (cnt_q == c_cnt_last) ? '0 : cnt_q + CW'(1);
        clk_out_d = clk_out_q ^ ((cnt_q == c_cnt_half) || tick);
        mode_d    = tick ? w_mode_now : mode_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            mode_q    <= LATENCY;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            mode_q    <= mode_d;
        end
    end

    assign clk_out = clk_out_q;
    assign mode    = (mode_q == RELIABILITY);

`ifdef ARB_SEL_EN
    logic [1:0] sel_q, sel_d;
    logic       sel_valid_q, sel_valid_d;

    // Selection follows the mode decided in this same tick cycle.
    always_comb begin
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        if (tick) begin
            sel_d       = pick_buffer(w_mode_now, l1, l2, l3, l4);
            sel_valid_d = ((l1 | l2 | l3 | l4) != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= 2'd0;
            sel_valid_q <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_buffer_score_core.sv
// +------------------------------------------------------------------+
// | tb_buffer_score_core : randomized scoreboard bench               |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_buffer_score_core;

    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] b1, b2, b3, b4;
    logic [2:0]  l1, l2, l3, l4;
    logic [5:0]  rs, ls;
    logic        tick, clk_out, mode;
`ifdef ARB_SEL_EN
    logic [1:0]  sel;
    logic        sel_valid;
`endif

    buffer_score_core #(.DIV_CYCLES(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .buffer1_i (b1),
        .buffer2_i (b2),
        .buffer3_i (b3),
        .buffer4_i (b4),
        .l1        (l1),
        .l2        (l2),
        .l3        (l3),
        .l4        (l4),
        .rs        (rs),
        .ls        (ls),
        .tick      (tick),
        .clk_out   (clk_out),
        .mode      (mode)
`ifdef ARB_SEL_EN
        ,
        .sel       (sel),
        .sel_valid (sel_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] l1, l2, l3, l4;
        logic [5:0] rs, ls;
        logic       tick, clk_out, mode;
        logic [1:0] sel;
        logic       sel_valid;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    int   cyc    = 0;
    bit   in_rst = 1'b1;
    bit   m_mode = 1'b0;
    int   m_sel  = 0;
    bit   m_sv   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int strict_max_idx(input int c[4]);
        int best = -1;
        for (int i = 0; i < 4; i++) begin
            bit above_all = 1'b1;
            for (int j = 0; j < 4; j++)
                if (j != i && c[i] <= c[j]) above_all = 1'b0;
            if (above_all) best = i;
        end
        return best;
    endfunction

    function automatic int pick_ref(input bit rel, input int c[4]);
        int m = strict_max_idx(c);
        if (!rel) begin
            if (m == 0 || m == 1) return m;
            return (c[2] > c[3]) ? 2 : 3;
        end
        if (m == 3 || m == 2) return m;
        return (c[1] > c[0]) ? 1 : 0;
    endfunction

    function automatic logic [17:0] rnd18();
        logic [31:0] r;
        r = $urandom();
        return r[17:0];
    endfunction

    // One clock interval: drive inputs, predict every output for it.
    task automatic step(input logic [17:0] a, input logic [17:0] b,
                        input logic [17:0] c, input logic [17:0] d,
                        input bit do_assert = 1'b0, input bit do_release = 1'b0);
        logic [17:0] bufs[4];
        int          cnt[4];
        int          srs, sls;
        exp_t        e;
        @(posedge clk);
        #1;
        b1 = a; b2 = b; b3 = c; b4 = d;
        if (do_release) begin
            rst_n  = 1'b1;
            in_rst = 1'b0;
            cyc    = 0;
        end
        if (do_assert) begin
            #2;
            rst_n  = 1'b0;
            in_rst = 1'b1;
            m_mode = 1'b0;
            m_sel  = 0;
            m_sv   = 1'b0;
        end
        bufs = '{a, b, c, d};
        srs = 0;
        sls = 0;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            for (int k = 0; k < 6; k++) cnt[i] += int'(bufs[i][3*k]);
            srs += (i + 1) * cnt[i];
            sls += (4 - i) * cnt[i];
        end
        e.l1 = 3'(cnt[0]); e.l2 = 3'(cnt[1]); e.l3 = 3'(cnt[2]); e.l4 = 3'(cnt[3]);
        e.rs = 6'(srs);
        e.ls = 6'(sls);
        if (in_rst) begin
            e.tick = 1'b0; e.clk_out = 1'b0; e.mode = 1'b0;
            e.sel = 2'd0;  e.sel_valid = 1'b0;
        end else begin
            cyc++;
            e.tick      = (cyc % DIV == 0);
            e.clk_out   = (((cyc - 1) % DIV) >= DIV / 2);
            e.mode      = m_mode;
            e.sel       = 2'(m_sel);
            e.sel_valid = m_sv;
        end
        q.push_back(e);
        if (!in_rst && e.tick) begin
            m_mode = (srs >= sls);
            m_sel  = pick_ref(m_mode, cnt);
            m_sv   = (cnt[0] + cnt[1] + cnt[2] + cnt[3]) != 0;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("l1", int'(l1), int'(e.l1));
                chk("l2", int'(l2), int'(e.l2));
                chk("l3", int'(l3), int'(e.l3));
                chk("l4", int'(l4), int'(e.l4));
                chk("rs", int'(rs), int'(e.rs));
                chk("ls", int'(ls), int'(e.ls));
                chk("tick", int'(tick), int'(e.tick));
                chk("clk_out", int'(clk_out), int'(e.clk_out));
                chk("mode", int'(mode), int'(e.mode));
`ifdef ARB_SEL_EN
                chk("sel", int'(sel), int'(e.sel));
                chk("sel_valid", int'(sel_valid), int'(e.sel_valid));
`endif
            end
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation time limit reached, got %0d expected 0 pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin : driver
        localparam logic [17:0] ALL_V  = 18'h3FFFF;
        localparam logic [17:0] B4_PAT = 18'b001_001_001_000_000_000;
        localparam logic [17:0] TIE    = 18'b000_000_000_001_001_001;
        bit found;
        b1 = '0; b2 = '0; b3 = '0; b4 = '0;

        step('0, '0, '0, '0);
        step('0, '0, '0, '0);
        step('0, '0, '0, '0, 1'b0, 1'b1);
        for (int i = 1; i < DIV; i++) step('0, '0, '0, '0);
        for (int i = 0; i < DIV; i++) step(ALL_V, '0, '0, '0);
        for (int i = 0; i < DIV; i++) step('0, '0, '0, B4_PAT);
        for (int i = 0; i < DIV; i++) step(TIE, TIE, '0, '0);
        for (int i = 0; i < 4 * DIV; i++) step(rnd18(), rnd18(), rnd18(), rnd18());

        // Reach cycle 7 of a period with reliability mode latched, then reset.
        found = 1'b0;
        for (int i = 0; i < 4 * DIV && !found; i++) begin
            if (m_mode && (cyc % DIV == 6)) found = 1'b1;
            else step('0, '0, '0, B4_PAT);
        end
        chk("reset_setup_reached", int'(found), 1);
        step('0, '0, '0, B4_PAT, 1'b1, 1'b0);
        step('0, '0, '0, B4_PAT);
        step('0, '0, '0, B4_PAT, 1'b0, 1'b1);
        for (int i = 0; i < 2 * DIV + 5; i++) step(rnd18(), rnd18(), rnd18(), rnd18());

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
